fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Forwarding-select and load-use hazard controller for the 16-bit five-stage pipeline (IF, ID, EX, MEM, WB). It sits upstream of the two ALU operand muxes and generates their 2-bit selects, registered into EX alongside the instruction. It tracks destination registers of in-flight instructions in EX and MEM. It stalls IF/ID and injects an EX bubble on a load-use hazard.

## Interface
Parameters:
- REG_ADDR_W, 3, register address width (8 architectural registers)
- ZERO_REG_EN, 1, when 1 register 0 reads as zero and is never a forwarding source

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  REG_ADDR_W  ID source register addresses
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2
- id_rd  in  REG_ADDR_W  ID destination register
- id_reg_write  in  1  ID instruction writes id_rd
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  kill the ID instruction (taken branch)
- mem_busy  in  1  data memory wait; freezes the whole pipeline
- stall  out  1  combinational; hold PC and IF/ID register
- ex_sel1, ex_sel2  out  2  registered operand selects for EX: 0 = reg1_val/reg2_val, 1 = MEM-stage forward, 2 = WB-stage forward; 3 is never driven
- ex_valid  out  1  registered; EX holds a real instruction (0 = bubble)

## Operation
- Internal state:
  - EX shadow: ex_rd, ex_wr, ex_ld, ex_valid
  - MEM shadow: mem_rd, mem_wr, mem_valid
- WB is not tracked. The register file is write-through: a same-cycle read returns the value being written.
- Source match rules:
  - Source s "hits EX" when id_use_s & ex_valid & ex_wr & (ex_rd == s) & !(ZERO_REG_EN & s == 0).
  - "Hits MEM" uses the same rule with the mem_* fields.
- Select computed in ID, registered into EX:
  - hits EX -> 1, because that producer is in MEM when the consumer reaches EX.
  - else hits MEM -> 2.
  - else 0.
  - EX priority over MEM: the newest producer wins.
- Load-use stall:
  - stall = id_valid & !flush & !mem_busy & ex_ld & (rs1 hits EX | rs2 hits EX).
  - Stall lasts exactly one cycle. On the next cycle the load is in MEM, the hit becomes a MEM hit, and the select is 2.
- Per clock edge with mem_busy = 0:
  - MEM shadow <= EX shadow.
  - If id_valid & !flush & !stall: EX shadow <= ID fields, ex_valid <= 1, ex_selN <= computed select.
  - Otherwise a bubble is inserted: ex_valid <= 0, ex_wr <= 0, ex_ld <= 0, ex_sel1 = ex_sel2 <= 0.
- mem_busy = 1: every register holds and stall = 0. The pipeline freeze comes from mem_busy itself. flush is ignored while mem_busy is high; the source holds flush until mem_busy drops.
- flush and a load-use hit in the same cycle: flush wins, stall = 0, and a bubble is inserted.
- A bubble (ex_valid = 0) is never a forwarding source. This covers pipeline fill after reset.

## Timing
- Reset (async, rst_n low) clears everything immediately:
  - ex_valid, ex_wr, ex_ld, mem_valid, mem_wr = 0
  - ex_rd, mem_rd = 0
  - ex_sel1, ex_sel2 = 0
  - stall = 0, combinationally, because ex_valid = 0
- Release of rst_n is synchronous to clk. The first edge with rst_n high performs normal updates.
- Select latency: computed in cycle N from ID, valid at EX in cycle N+1. Registered outputs need no combinational path to the ALU mux.
- stall is combinational in the same cycle from ID inputs and EX shadow. It does not depend on ex_sel*.
- Reset asserted mid-stall clears the shadows. No stall or bubble state survives reset.
- Maximum consecutive stall cycles from one load is 1, independent of mem_busy gaps.

## Test plan
- ADD r1 followed immediately by ADD r2,r1,r3 -> when the consumer is in EX: ex_sel1 = 1, ex_sel2 = 0, stall never asserted.
- ADD r1, NOP, SUB r4,r5,r1 -> consumer in EX: ex_sel1 = 0, ex_sel2 = 2.
- ADD r3, ADD r3, OR r6,r3,r3 -> OR in EX: ex_sel1 = ex_sel2 = 1 (EX priority over MEM).
- LOAD r4 then ADD r5,r4,r4 -> stall = 1 for exactly one cycle, then a bubble in EX (ex_valid = 0). The ADD then enters EX with ex_sel1 = ex_sel2 = 2.
- Writer with rd = r0 followed by a reader of r0, ZERO_REG_EN = 1 -> ex_sel1 = 0. LOAD r2 then a use of r2 with flush = 1 -> stall = 0 and a bubble is inserted.
- LOAD r7 then a use of r7, with mem_busy held 3 cycles during the stall window -> all outputs hold and stall = 0 while busy. After release: one stall cycle, then ex_sel = 2. Pulsing rst_n low mid-sequence clears all outputs to 0 immediately.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - forwarding-select and load-use hazard controller
//
// Purpose: tracks destination registers of the instructions in EX and MEM,
// computes the two ALU operand-mux selects in ID and registers them into EX,
// and stalls IF/ID with an EX bubble on a load-use hazard.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   id_valid                   ID holds a real instruction
//   id_rs1/id_rs2              ID source register addresses
//   id_use_rs1/id_use_rs2      instruction reads rs1 / rs2
//   id_rd, id_reg_write        ID destination and its write enable
//   id_mem_read                ID instruction is a load
//   flush                      kill the ID instruction
//   mem_busy                   data memory wait, freezes everything
//   stall                      combinational hold of PC and IF/ID
//   ex_sel1/ex_sel2            registered selects: 0 reg, 1 MEM fwd, 2 WB fwd
//   ex_valid                   registered, EX holds a real instruction
module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = 3,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  input  logic                  mem_busy,
  output logic                  stall,
  output logic [1:0]            ex_sel1,
  output logic [1:0]            ex_sel2,
  output logic                  ex_valid
);

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // EX shadow
  logic [REG_ADDR_W-1:0] ex_rd_q,    ex_rd_d;
  logic                  ex_wr_q,    ex_wr_d;
  logic                  ex_ld_q,    ex_ld_d;
  logic                  ex_valid_q, ex_valid_d;
  logic [1:0]            ex_sel1_q,  ex_sel1_d;
  logic [1:0]            ex_sel2_q,  ex_sel2_d;
  // MEM shadow
  logic [REG_ADDR_W-1:0] mem_rd_q,    mem_rd_d;
  logic                  mem_wr_q,    mem_wr_d;
  logic                  mem_valid_q, mem_valid_d;

  logic rs1_is_zero, rs2_is_zero;
  logic rs1_hit_ex, rs2_hit_ex;
  logic rs1_hit_mem, rs2_hit_mem;
  logic [1:0] sel1_id, sel2_id;
  logic accept;

  // Register 0 is hardwired to zero, so it can never be a forwarding source.
  assign rs1_is_zero = ZERO_REG_EN && (id_rs1 == '0);
  assign rs2_is_zero = ZERO_REG_EN && (id_rs2 == '0);

  // Bubbles (valid = 0) and non-writers never match.
  assign rs1_hit_ex  = id_use_rs1 && ex_valid_q && ex_wr_q && (ex_rd_q == id_rs1) && !rs1_is_zero;
  assign rs2_hit_ex  = id_use_rs2 && ex_valid_q && ex_wr_q && (ex_rd_q == id_rs2) && !rs2_is_zero;
  assign rs1_hit_mem = id_use_rs1 && mem_valid_q && mem_wr_q && (mem_rd_q == id_rs1) && !rs1_is_zero;
  assign rs2_hit_mem = id_use_rs2 && mem_valid_q && mem_wr_q && (mem_rd_q == id_rs2) && !rs2_is_zero;

  // Producer in EX now is in MEM when the consumer reaches EX, and it is the
  // newest value, so it takes priority over the older MEM producer.
  assign sel1_id = rs1_hit_ex ? SEL_MEM : (rs1_hit_mem ? SEL_WB : SEL_REG);
  assign sel2_id = rs2_hit_ex ? SEL_MEM : (rs2_hit_mem ? SEL_WB : SEL_REG);

  // A load's data is not available until it leaves MEM, so a consumer directly
  // behind it waits one cycle; after that the hit becomes a MEM hit.
  assign stall  = id_valid && !flush && !mem_busy && ex_ld_q && (rs1_hit_ex || rs2_hit_ex);
  assign accept = id_valid && !flush && !stall;

  always_comb begin
    ex_rd_d     = ex_rd_q;
    ex_wr_d     = ex_wr_q;
    ex_ld_d     = ex_ld_q;
    ex_valid_d  = ex_valid_q;
    ex_sel1_d   = ex_sel1_q;
    ex_sel2_d   = ex_sel2_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_valid_d = mem_valid_q;
    if (!mem_busy) begin
      mem_rd_d    = ex_rd_q;
      mem_wr_d    = ex_wr_q;
      mem_valid_d = ex_valid_q;
      if (accept) begin
        ex_rd_d    = id_rd;
        ex_wr_d    = id_reg_write;
        ex_ld_d    = id_mem_read;
        ex_valid_d = 1'b1;
        ex_sel1_d  = sel1_id;
        ex_sel2_d  = sel2_id;
      end else begin
        ex_wr_d    = 1'b0;
        ex_ld_d    = 1'b0;
        ex_valid_d = 1'b0;
        ex_sel1_d  = SEL_REG;
        ex_sel2_d  = SEL_REG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rd_q     <= '0;
      ex_wr_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      ex_valid_q  <= 1'b0;
      ex_sel1_q   <= SEL_REG;
      ex_sel2_q   <= SEL_REG;
      mem_rd_q    <= '0;
      mem_wr_q    <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      ex_rd_q     <= ex_rd_d;
      ex_wr_q     <= ex_wr_d;
      ex_ld_q     <= ex_ld_d;
      ex_valid_q  <= ex_valid_d;
      ex_sel1_q   <= ex_sel1_d;
      ex_sel2_q   <= ex_sel2_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign ex_sel1  = ex_sel1_q;
  assign ex_sel2  = ex_sel2_q;
  assign ex_valid = ex_valid_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - self-checking bench for fwd_hazard_unit
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
  logic       flush = 1'b0, mem_busy = 1'b0;
  logic       stall;
  logic [1:0] ex_sel1, ex_sel2;
  logic       ex_valid;

  int errors = 0;
  int checks = 0;

  fwd_hazard_unit #(.REG_ADDR_W(3), .ZERO_REG_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .flush(flush), .mem_busy(mem_busy), .stall(stall),
    .ex_sel1(ex_sel1), .ex_sel2(ex_sel2), .ex_valid(ex_valid)
  );

  always #5 clk = ~clk;

  // Model: in-flight producers by distance ahead of ID (0 = one stage ahead,
  // 1 = two stages ahead). A consumer forwards from the nearest producer;
  // distance d yields select d+1.
  typedef struct {
    logic       live;
    logic [2:0] rd;
    logic       ld;
  } prod_t;

  prod_t      prod[2];
  logic [1:0] m_sel1 = '0, m_sel2 = '0;
  logic       m_valid = 1'b0;

  initial begin
    for (int i = 0; i < 2; i++) prod[i] = '{live: 1'b0, rd: 3'd0, ld: 1'b0};
  end

  function automatic logic [1:0] model_sel(input logic use_s, input logic [2:0] s);
    logic [1:0] r;
    r = 2'd0;
    if (use_s && s != 3'd0) begin
      for (int d = 1; d >= 0; d--)
        if (prod[d].live && prod[d].rd == s) r = 2'(d + 1);
    end
    return r;
  endfunction

  function automatic logic model_stall();
    return id_valid && !flush && !mem_busy && prod[0].ld &&
           (model_sel(id_use_rs1, id_rs1) == 2'd1 || model_sel(id_use_rs2, id_rs2) == 2'd1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_upd
    logic       acc;
    logic [1:0] s1, s2;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) prod[i] = '{live: 1'b0, rd: 3'd0, ld: 1'b0};
      m_sel1 = 2'd0; m_sel2 = 2'd0; m_valid = 1'b0;
    end else if (!mem_busy) begin
      acc = id_valid && !flush && !model_stall();
      s1  = model_sel(id_use_rs1, id_rs1);
      s2  = model_sel(id_use_rs2, id_rs2);
      prod[1] = prod[0];
      if (acc) begin
        prod[0] = '{live: id_reg_write, rd: id_rd, ld: id_mem_read};
        m_valid = 1'b1; m_sel1 = s1; m_sel2 = s2;
      end else begin
        prod[0] = '{live: 1'b0, rd: 3'd0, ld: 1'b0};
        m_valid = 1'b0; m_sel1 = 2'd0; m_sel2 = 2'd0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every falling edge, DUT against model.
  always @(negedge clk) begin
    chk("model_stall", int'(stall), int'(model_stall()));
    chk("model_ex_valid", int'(ex_valid), int'(m_valid));
    chk("model_ex_sel1", int'(ex_sel1), int'(m_sel1));
    chk("model_ex_sel2", int'(ex_sel2), int'(m_sel2));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [2:0] rs1, input logic u1,
                     input logic [2:0] rs2, input logic u2, input logic [2:0] rd,
                     input logic wr, input logic ld, input logic fl, input logic bz);
    id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_mem_read = ld; flush = fl; mem_busy = bz;
    #1;
  endtask

  task automatic idle();
    put(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ex_valid", int'(ex_valid), 0);
    chk("reset_sel1", int'(ex_sel1), 0);
    chk("reset_stall", int'(stall), 0);
    rst_n = 1'b1;
    idle();
    tick();

    // ADD r1 ; ADD r2,r1,r3
    put(1, 3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 0, 0); tick();
    put(1, 3'd1, 1, 3'd3, 1, 3'd2, 1, 0, 0, 0);
    chk("fwd_ex_stall", int'(stall), 0);
    tick();
    chk("fwd_ex_sel1", int'(ex_sel1), 1);
    chk("fwd_ex_sel2", int'(ex_sel2), 0);
    chk("fwd_ex_valid", int'(ex_valid), 1);

    // ADD r1 ; NOP ; SUB r4,r5,r1
    put(1, 3'd2, 1, 3'd3, 1, 3'd1, 1, 0, 0, 0); tick();
    idle(); tick();
    put(1, 3'd5, 1, 3'd1, 1, 3'd4, 1, 0, 0, 0); tick();
    chk("fwd_mem_sel1", int'(ex_sel1), 0);
    chk("fwd_mem_sel2", int'(ex_sel2), 2);

    // ADD r3 ; ADD r3 ; OR r6,r3,r3
    put(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0); tick();
    put(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0); tick();
    put(1, 3'd3, 1, 3'd3, 1, 3'd6, 1, 0, 0, 0); tick();
    chk("prio_sel1", int'(ex_sel1), 1);
    chk("prio_sel2", int'(ex_sel2), 1);

    // LOAD r4 ; ADD r5,r4,r4
    put(1, 3'd1, 1, 3'd0, 0, 3'd4, 1, 1, 0, 0); tick();
    put(1, 3'd4, 1, 3'd4, 1, 3'd5, 1, 0, 0, 0);
    chk("lu_stall", int'(stall), 1);
    tick();
    chk("lu_bubble", int'(ex_valid), 0);
    chk("lu_stall_once", int'(stall), 0);
    tick();
    chk("lu_valid", int'(ex_valid), 1);
    chk("lu_sel1", int'(ex_sel1), 2);
    chk("lu_sel2", int'(ex_sel2), 2);

    // writer r0 ; reader r0
    put(1, 3'd1, 0, 3'd1, 0, 3'd0, 1, 0, 0, 0); tick();
    put(1, 3'd0, 1, 3'd0, 0, 3'd1, 1, 0, 0, 0); tick();
    chk("r0_sel1", int'(ex_sel1), 0);

    // LOAD r2 ; use r2 with flush
    put(1, 3'd1, 1, 3'd0, 0, 3'd2, 1, 1, 0, 0); tick();
    put(1, 3'd2, 1, 3'd0, 0, 3'd3, 1, 0, 1, 0);
    chk("flush_stall", int'(stall), 0);
    tick();
    chk("flush_bubble", int'(ex_valid), 0);

    // LOAD r7 ; use r7 with mem_busy for 3 cycles
    put(1, 3'd1, 1, 3'd0, 0, 3'd7, 1, 1, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      put(1, 3'd7, 1, 3'd0, 0, 3'd3, 1, 0, 0, 1);
      chk("busy_stall", int'(stall), 0);
      tick();
      chk("busy_hold_valid", int'(ex_valid), 1);
    end
    put(1, 3'd7, 1, 3'd0, 0, 3'd3, 1, 0, 0, 0);
    chk("busy_post_stall", int'(stall), 1);
    tick();
    chk("busy_post_bubble", int'(ex_valid), 0);
    tick();
    chk("busy_post_sel1", int'(ex_sel1), 2);

    // reset pulse mid-stall
    put(1, 3'd2, 1, 3'd0, 0, 3'd1, 1, 1, 0, 0); tick();
    put(1, 3'd1, 1, 3'd1, 1, 3'd3, 1, 0, 0, 0);
    chk("pre_rst_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", int'(stall), 0);
    chk("rst_valid", int'(ex_valid), 0);
    chk("rst_sel1", int'(ex_sel1), 0);
    chk("rst_sel2", int'(ex_sel2), 0);
    tick();
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      put(($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 3),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 15));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
